updown_counter_pro: RTL and testbench

UPDOWN_COUNTER_PRO -- requirements
Module: updown_counter_pro

---
 rtl/updown_counter_pro_if.sv | 36 +++
 rtl/updown_counter_pro.sv | 168 ++++++++++++++++
 tb/tb_updown_counter_pro.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_pro_if.sv
// Bus bundle for updown_counter_pro: control/configuration inputs and
// counter status outputs. clk and rstn stay as plain module ports.
interface updown_counter_pro_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              ena;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              up_down;
  logic              hold;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic              start;
  logic              ovf_clr;
  logic [WIDTH-1:0]  cnt;
  logic              tc;
  logic              busy;
  logic              ovf_sticky;
  logic              cfg_err;

  modport master (
    output ena, clr, load, load_val, up_down, hold, lo, hi, step, mode,
           start, ovf_clr,
    input  cnt, tc, busy, ovf_sticky, cfg_err
  );

  modport slave (
    input  ena, clr, load, load_val, up_down, hold, lo, hi, step, mode,
           start, ovf_clr,
    output cnt, tc, busy, ovf_sticky, cfg_err
  );
endinterface

// File: rtl/updown_counter_pro.sv
// Up/down counter with programmable limits and step, wrap / saturate /
// one-shot modes, terminal-count pulse and sticky overflow flag.
module updown_counter_pro #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  updown_counter_pro_if.slave bus
);

  // Arithmetic width: one bit wider than the wider operand so that both the
  // up-carry and the down-borrow are visible.
  localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              tc_q, tc_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              ovf_set_s;

  logic [AW-1:0]     cnt_ext_s, step_ext_s, lo_ext_s, hi_ext_s, nxt_s;
  logic              up_s, step_nz_s, borrow_s, lim_s, over_s, cfg_err_s;
  logic [WIDTH-1:0]  tgt_s, far_s;
  logic [1:0]        mode_s;

  assign up_s       = bus.up_down;
  assign cfg_err_s  = (bus.lo > bus.hi);
  // Mode 11 behaves exactly like saturate.
  assign mode_s     = (bus.mode == 2'b11) ? MODE_SAT : bus.mode;

  assign cnt_ext_s  = AW'(cnt_q);
  assign step_ext_s = AW'(bus.step);
  assign lo_ext_s   = AW'(bus.lo);
  assign hi_ext_s   = AW'(bus.hi);
  assign nxt_s      = up_s ? (cnt_ext_s + step_ext_s) : (cnt_ext_s - step_ext_s);
  // A down result can only set the top bit by borrowing.
  assign borrow_s   = !up_s && nxt_s[AW-1];
  assign step_nz_s  = (bus.step != {STEP_W{1'b0}});

  // Limit reached or passed in the current direction.
  assign lim_s  = step_nz_s && (up_s ? (nxt_s >= hi_ext_s)
                                     : (borrow_s || (nxt_s <= lo_ext_s)));
  // Strictly past the limit.
  assign over_s = step_nz_s && (up_s ? (nxt_s > hi_ext_s)
                                     : (borrow_s || (nxt_s < lo_ext_s)));

  // Limit being approached, and the opposite end (wrap target / launch value).
  assign tgt_s = up_s ? bus.hi : bus.lo;
  assign far_s = up_s ? bus.lo : bus.hi;

  // Next-state logic: priority chain, then per-mode counting and one-shot FSM.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    tc_d      = 1'b0;
    ovf_set_s = 1'b0;
    busy_d    = 1'b0;

    if (!bus.ena) begin
      cnt_d   = {WIDTH{1'b0}};
      state_d = ST_IDLE;
    end else if (bus.clr) begin
      cnt_d = bus.lo;
    end else if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (bus.hold || cfg_err_s) begin
      cnt_d = cnt_q;
    end else if ((state_q != ST_IDLE) && (mode_s != MODE_ONESHOT)) begin
      // Mode left one-shot mid-sequence: park the FSM, keep the count.
      state_d = ST_IDLE;
    end else begin
      case (mode_s)
        MODE_WRAP: begin
          if (lim_s) begin
            tc_d      = 1'b1;
            ovf_set_s = over_s;
            cnt_d     = over_s ? far_s : tgt_s;
          end else begin
            cnt_d = nxt_s[WIDTH-1:0];
          end
        end
        MODE_SAT: begin
          if (lim_s) begin
            ovf_set_s = over_s;
            cnt_d     = tgt_s;
            // Already parked at the limit: a repeated clamp is silent.
            tc_d      = (cnt_q != tgt_s);
          end else begin
            cnt_d = nxt_s[WIDTH-1:0];
          end
        end
        MODE_ONESHOT: begin
          case (state_q)
            ST_IDLE, ST_DONE: begin
              if (bus.start) begin
                state_d = ST_RUN;
                cnt_d   = far_s;
              end else begin
                cnt_d = cnt_q;
              end
            end
            ST_RUN: begin
              if (lim_s) begin
                cnt_d     = tgt_s;
                tc_d      = 1'b1;
                ovf_set_s = over_s;
                state_d   = ST_DONE;
              end else begin
                cnt_d = nxt_s[WIDTH-1:0];
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end

    if (mode_s == MODE_ONESHOT) begin
      busy_d = (state_d == ST_RUN);
    end else begin
      busy_d = bus.ena && !bus.hold && !cfg_err_s && step_nz_s;
    end

    // A new overflow event wins over a simultaneous clear request.
    ovf_d = ovf_set_s || (ovf_q && !bus.ovf_clr);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = busy_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.cfg_err    = cfg_err_s;

endmodule

// File: tb/tb_updown_counter_pro.sv
// Directed self-checking bench for updown_counter_pro: expected outputs are
// queued when stimulus is applied and compared after the following edge.
module tb_updown_counter_pro;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  updown_counter_pro_if #(.WIDTH(8),  .STEP_W(4)) if8 ();
  updown_counter_pro_if #(.WIDTH(16), .STEP_W(4)) if16 ();

  updown_counter_pro #(.WIDTH(8), .STEP_W(4)) dut8 (
    .clk (clk),
    .rstn(rstn),
    .bus (if8)
  );

  updown_counter_pro #(.WIDTH(16), .STEP_W(4)) dut16 (
    .clk (clk),
    .rstn(rstn),
    .bus (if16)
  );

  typedef struct {
    bit          sel;    // 0 = 8-bit DUT, 1 = 16-bit DUT
    string       tag;
    logic [15:0] cnt;
    logic        tc;
    logic        busy;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input string tag, input logic [15:0] c,
                      input logic t, input logic b, input logic o);
    exp_t e;
    e.sel = sel; e.tag = tag; e.cnt = c; e.tc = t; e.busy = b; e.ovf = o;
    sbq.push_back(e);
  endtask

  // Advance one edge, then drain the scoreboard against the DUT outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.sel) begin
        chk({e.tag, "_cnt"},  {16'h0, if16.cnt},        {16'h0, e.cnt});
        chk({e.tag, "_tc"},   {31'h0, if16.tc},         {31'h0, e.tc});
        chk({e.tag, "_busy"}, {31'h0, if16.busy},       {31'h0, e.busy});
        chk({e.tag, "_ovf"},  {31'h0, if16.ovf_sticky}, {31'h0, e.ovf});
      end else begin
        chk({e.tag, "_cnt"},  {24'h0, if8.cnt},         {16'h0, e.cnt});
        chk({e.tag, "_tc"},   {31'h0, if8.tc},          {31'h0, e.tc});
        chk({e.tag, "_busy"}, {31'h0, if8.busy},        {31'h0, e.busy});
        chk({e.tag, "_ovf"},  {31'h0, if8.ovf_sticky},  {31'h0, e.ovf});
      end
    end
  endtask

  task automatic s8(input string tag, input logic [7:0] c,
                    input logic t, input logic b, input logic o);
    push(1'b0, tag, {8'h0, c}, t, b, o);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    if8.ena = 1'b0;  if8.clr = 1'b0;  if8.load = 1'b0;  if8.load_val = 8'h00;
    if8.up_down = 1'b1; if8.hold = 1'b0; if8.lo = 8'h00; if8.hi = 8'h00;
    if8.step = 4'h0; if8.mode = 2'b00; if8.start = 1'b0; if8.ovf_clr = 1'b0;
    if16.ena = 1'b0; if16.clr = 1'b0; if16.load = 1'b0; if16.load_val = 16'h0;
    if16.up_down = 1'b1; if16.hold = 1'b0; if16.lo = 16'h0; if16.hi = 16'h0;
    if16.step = 4'h0; if16.mode = 2'b00; if16.start = 1'b0; if16.ovf_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_cnt",  {24'h0, if8.cnt},        32'h0);
    chk("rst_tc",   {31'h0, if8.tc},         32'h0);
    chk("rst_busy", {31'h0, if8.busy},       32'h0);
    chk("rst_ovf",  {31'h0, if8.ovf_sticky}, 32'h0);
    chk("rst_cnt16", {16'h0, if16.cnt},      32'h0);
    chk("rst_cfg16", {31'h0, if16.cfg_err},  32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Wrap mode, lo=10 hi=20 step=3 up from 18
    if8.ena = 1'b1; if8.mode = 2'b00; if8.lo = 8'd10; if8.hi = 8'd20;
    if8.step = 4'd3; if8.up_down = 1'b1; if8.load = 1'b1; if8.load_val = 8'd18;
    s8("a_load", 8'd18, 1'b0, 1'b1, 1'b0);
    if8.load = 1'b0;
    s8("a_wrap1", 8'd10, 1'b1, 1'b1, 1'b1);
    s8("a_13",    8'd13, 1'b0, 1'b1, 1'b1);
    s8("a_16",    8'd16, 1'b0, 1'b1, 1'b1);
    s8("a_19",    8'd19, 1'b0, 1'b1, 1'b1);
    s8("a_wrap2", 8'd10, 1'b1, 1'b1, 1'b1);
    if8.ovf_clr = 1'b1;
    s8("a_ovfclr", 8'd13, 1'b0, 1'b1, 1'b0);
    if8.ovf_clr = 1'b0;

    // Configuration error freezes counting but not load
    if8.lo = 8'd30;
    #1;
    chk("cfg_err_set", {31'h0, if8.cfg_err}, 32'h1);
    s8("cfg_freeze", 8'd13, 1'b0, 1'b0, 1'b0);
    if8.load = 1'b1; if8.load_val = 8'h42;
    s8("cfg_load", 8'h42, 1'b0, 1'b0, 1'b0);
    if8.load = 1'b0; if8.lo = 8'd10;
    #1;
    chk("cfg_err_clr", {31'h0, if8.cfg_err}, 32'h0);

    // clr, hold, step=0, lo==hi
    if8.clr = 1'b1;
    s8("clr", 8'd10, 1'b0, 1'b1, 1'b0);
    if8.clr = 1'b0; if8.hold = 1'b1;
    s8("hold00", 8'd10, 1'b0, 1'b0, 1'b0);
    if8.hold = 1'b0; if8.step = 4'd0;
    s8("step0", 8'd10, 1'b0, 1'b0, 1'b0);
    if8.step = 4'd3; if8.hi = 8'd10;
    s8("lohi1", 8'd10, 1'b1, 1'b1, 1'b1);
    s8("lohi2", 8'd10, 1'b1, 1'b1, 1'b1);
    if8.hi = 8'd20;

    // Saturate mode, down, lo=5 step=4 from 7
    if8.mode = 2'b01; if8.up_down = 1'b0; if8.lo = 8'd5; if8.step = 4'd4;
    if8.load = 1'b1; if8.load_val = 8'd7; if8.ovf_clr = 1'b1;
    s8("b_load", 8'd7, 1'b0, 1'b1, 1'b0);
    if8.load = 1'b0; if8.ovf_clr = 1'b0;
    s8("b_clamp", 8'd5, 1'b1, 1'b1, 1'b1);
    s8("b_rep_lo", 8'd5, 1'b0, 1'b1, 1'b1);
    if8.ovf_clr = 1'b1;
    s8("b_set_wins", 8'd5, 1'b0, 1'b1, 1'b1);
    if8.ovf_clr = 1'b0; if8.mode = 2'b11;
    s8("b_mode11", 8'd5, 1'b0, 1'b1, 1'b1);
    if8.up_down = 1'b1; if8.load = 1'b1; if8.load_val = 8'd18;
    s8("b_load18", 8'd18, 1'b0, 1'b1, 1'b1);
    if8.load = 1'b0;
    s8("b_clamp_hi", 8'd20, 1'b1, 1'b1, 1'b1);
    s8("b_rep_hi", 8'd20, 1'b0, 1'b1, 1'b1);

    // One-shot mode, up lo=0 hi=6 step=2
    if8.mode = 2'b10; if8.lo = 8'd0; if8.hi = 8'd6; if8.step = 4'd2;
    if8.start = 1'b1; if8.ovf_clr = 1'b1;
    s8("c_start", 8'd0, 1'b0, 1'b1, 1'b0);
    if8.start = 1'b0; if8.ovf_clr = 1'b0;
    s8("c_2", 8'd2, 1'b0, 1'b1, 1'b0);
    s8("c_4", 8'd4, 1'b0, 1'b1, 1'b0);
    s8("c_6", 8'd6, 1'b1, 1'b0, 1'b0);
    s8("c_done", 8'd6, 1'b0, 1'b0, 1'b0);
    if8.start = 1'b1;
    s8("c_restart", 8'd0, 1'b0, 1'b1, 1'b0);
    if8.start = 1'b0;
    s8("c_r2", 8'd2, 1'b0, 1'b1, 1'b0);
    if8.start = 1'b1;
    s8("c_start_ign", 8'd4, 1'b0, 1'b1, 1'b0);
    if8.start = 1'b0; if8.hold = 1'b1;
    for (int i = 0; i < 3; i++) s8("c_hold", 8'd4, 1'b0, 1'b1, 1'b0);
    if8.hold = 1'b0;
    s8("c_after_hold", 8'd6, 1'b1, 1'b0, 1'b0);
    if8.start = 1'b1;
    s8("d_start", 8'd0, 1'b0, 1'b1, 1'b0);
    if8.start = 1'b0;
    s8("d_2", 8'd2, 1'b0, 1'b1, 1'b0);
    if8.ena = 1'b0;
    s8("d_ena_off", 8'd0, 1'b0, 1'b0, 1'b0);
    if8.ena = 1'b1;
    s8("d_idle_wait", 8'd0, 1'b0, 1'b0, 1'b0);

    // Mode change mid-run parks the FSM without touching cnt
    if8.start = 1'b1;
    s8("m_start", 8'd0, 1'b0, 1'b1, 1'b0);
    if8.start = 1'b0;
    s8("m_2", 8'd2, 1'b0, 1'b1, 1'b0);
    if8.mode = 2'b00;
    s8("m_change", 8'd2, 1'b0, 1'b1, 1'b0);
    s8("m_wrap_cnt", 8'd4, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges at cnt=0x55 with flags set
    if8.lo = 8'h50; if8.hi = 8'h55; if8.load = 1'b1; if8.load_val = 8'h54;
    s8("r_load54", 8'h54, 1'b0, 1'b1, 1'b0);
    if8.load = 1'b0;
    s8("r_over", 8'h50, 1'b1, 1'b1, 1'b1);
    if8.load = 1'b1; if8.load_val = 8'h53;
    s8("r_load53", 8'h53, 1'b0, 1'b1, 1'b1);
    if8.load = 1'b0;
    s8("r_55", 8'h55, 1'b1, 1'b1, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_cnt",  {24'h0, if8.cnt},        32'h0);
    chk("ar_tc",   {31'h0, if8.tc},         32'h0);
    chk("ar_busy", {31'h0, if8.busy},       32'h0);
    chk("ar_ovf",  {31'h0, if8.ovf_sticky}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    s8("ar_first_edge", 8'd2, 1'b0, 1'b1, 1'b0);

    // Reset mid-run aborts and waits in IDLE
    if8.mode = 2'b10; if8.lo = 8'd0; if8.hi = 8'd6; if8.start = 1'b1;
    s8("rr_start", 8'd0, 1'b0, 1'b1, 1'b0);
    if8.start = 1'b0;
    s8("rr_2", 8'd2, 1'b0, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("rr_cnt",  {24'h0, if8.cnt},  32'h0);
    chk("rr_busy", {31'h0, if8.busy}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    s8("rr_idle", 8'd0, 1'b0, 1'b0, 1'b0);

    // 16-bit wrap mode, down from 1 by 5 over full range: borrow
    if16.ena = 1'b1; if16.mode = 2'b00; if16.lo = 16'h0000; if16.hi = 16'hFFFF;
    if16.up_down = 1'b0; if16.step = 4'd5; if16.load = 1'b1; if16.load_val = 16'h0001;
    push(1'b1, "w16_load", 16'h0001, 1'b0, 1'b1, 1'b0);
    tick();
    if16.load = 1'b0;
    push(1'b1, "w16_borrow", 16'hFFFF, 1'b1, 1'b1, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
